// File: rtl/clk_divider_pkg.sv
// Shared definitions for the multi-channel clock divider.
//   DEF_CNT_W      : default counter/divisor width
//   DIV_BYPASS_MAX : divisors at or below this value run as divide-by-1
//   eff_div()      : maps a programmed divisor to the effective period D
// Optional feature macro: CLK_DIVIDER_MULTI_PHASE_EN (used by the channel/top).
package clk_divider_pkg;

   localparam int unsigned DEF_CNT_W      = 16;
   localparam int unsigned DIV_BYPASS_MAX = 1;

   // Widened to 32 bits so one function serves every CNT_W up to 32.
   function automatic logic [31:0] eff_div(input logic [31:0] div);
      return (div <= 32'(DIV_BYPASS_MAX)) ? 32'd1 : div;
   endfunction

endpackage

// File: rtl/clk_div_channel.sv
// One divider channel: counter, active/staged divisor, pending flag,
// registered tick and divided clock.
// Ports:
//   clk, rst      : system clock, async active-high reset
//   en            : run enable
//   sync_restart  : realign counter, apply any staged divisor now
//   wr            : accepted divisor write for this channel
//   wr_div        : divisor being written
//   wr_phase      : start phase (only with CLK_DIVIDER_MULTI_PHASE_EN)
//   pending       : staged divisor waiting for terminal count
//   tick          : one-cycle pulse when cnt == D-1
//   clk_out       : 1 while cnt >= D/2 (held 0 for D == 1)
//   div           : active divisor
module clk_div_channel
   import clk_divider_pkg::*;
#(
   parameter int unsigned CNT_W       = DEF_CNT_W,
   parameter int unsigned DEFAULT_DIV = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             sync_restart,
   input  logic             wr,
   input  logic [CNT_W-1:0] wr_div,
`ifdef CLK_DIVIDER_MULTI_PHASE_EN
   input  logic [CNT_W-1:0] wr_phase,
`endif
   output logic             pending,
   output logic             tick,
   output logic             clk_out,
   output logic [CNT_W-1:0] div
);

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [CNT_W-1:0] div_q, div_d;
   logic [CNT_W-1:0] stage_q, stage_d;
   logic             pending_q, pending_d;
   logic             tick_q, tick_d;
   logic             clk_out_q, clk_out_d;
   logic             en_q, en_d;
   logic [CNT_W-1:0] d_cur, d_nxt, d_max;
   logic             phase_load;
   logic             outs_ok;
`ifdef CLK_DIVIDER_MULTI_PHASE_EN
   logic [CNT_W-1:0] stage_phase_q, stage_phase_d;
`endif

   always_comb begin
      stage_d    = stage_q;
      pending_d  = pending_q;
      div_d      = div_q;
      en_d       = en;
      cnt_d      = cnt_q + CNT_W'(1);
      phase_load = 1'b0;
      d_cur      = CNT_W'(eff_div(32'(div_q)));
`ifdef CLK_DIVIDER_MULTI_PHASE_EN
      stage_phase_d = stage_phase_q;
`endif

      if (wr) begin
         stage_d   = wr_div;
         pending_d = 1'b1;
`ifdef CLK_DIVIDER_MULTI_PHASE_EN
         stage_phase_d = wr_phase;
`endif
      end

      // Staged values are taken from the _d copies on restart so a write
      // accepted in the same cycle is applied at once.
      if (sync_restart) begin
         if (pending_d) begin
            div_d     = stage_d;
            pending_d = 1'b0;
         end
         cnt_d      = '0;
         phase_load = 1'b1;
      end else if (!en || !en_q) begin
         // Idle, or first enabled cycle: hold at 0 so the first tick lands
         // D cycles after enable; a staged divisor can be applied freely.
         if (pending_q) begin
            div_d     = stage_q;
            pending_d = 1'b0;
         end
         cnt_d = '0;
      end else if (cnt_q == d_cur - CNT_W'(1)) begin
         cnt_d = '0;
         if (pending_q) begin
            div_d      = stage_q;
            pending_d  = 1'b0;
            phase_load = 1'b1;
         end
      end

      d_nxt = CNT_W'(eff_div(32'(div_d)));
      d_max = d_nxt - CNT_W'(1);

`ifdef CLK_DIVIDER_MULTI_PHASE_EN
      if (phase_load)
         cnt_d = (stage_phase_d > d_max) ? d_max : stage_phase_d;
      outs_ok = en;
`else
      outs_ok = en && !sync_restart;
`endif
      if (!en)
         cnt_d = '0;

      // Outputs come from the next count so they line up with cnt_q.
      tick_d    = outs_ok && (cnt_d == d_max);
      clk_out_d = outs_ok && (d_nxt > CNT_W'(1)) && (cnt_d >= (d_nxt >> 1));
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q     <= '0;
         div_q     <= CNT_W'(DEFAULT_DIV);
         stage_q   <= '0;
         pending_q <= 1'b0;
         tick_q    <= 1'b0;
         clk_out_q <= 1'b0;
         en_q      <= 1'b0;
`ifdef CLK_DIVIDER_MULTI_PHASE_EN
         stage_phase_q <= '0;
`endif
      end else begin
         cnt_q     <= cnt_d;
         div_q     <= div_d;
         stage_q   <= stage_d;
         pending_q <= pending_d;
         tick_q    <= tick_d;
         clk_out_q <= clk_out_d;
         en_q      <= en_d;
`ifdef CLK_DIVIDER_MULTI_PHASE_EN
         stage_phase_q <= stage_phase_d;
`endif
      end
   end

   assign pending = pending_q;
   assign tick    = tick_q;
   assign clk_out = clk_out_q;
   assign div     = div_q;

endmodule

// File: rtl/clk_divider_multi.sv
// Multi-channel programmable clock-enable generator.
// Ports:
//   clk, rst      : system clock, async active-high reset
//   ch_en         : per-channel run enable
//   sync_restart  : realign all channels, apply staged divisors
//   cfg_valid/cfg_ready/cfg_ch/cfg_div : divisor write handshake
//   cfg_phase     : start phase, only with CLK_DIVIDER_MULTI_PHASE_EN
//   tick          : per-channel one-cycle pulse per period
//   clk_out       : per-channel registered divided clock
//   div_cur       : active divisors, ch0 in LSBs
// Optional feature macro: CLK_DIVIDER_MULTI_PHASE_EN.
module clk_divider_multi
   import clk_divider_pkg::*;
#(
   parameter  int unsigned NUM_CH      = 4,
   parameter  int unsigned CNT_W       = DEF_CNT_W,
   parameter  int unsigned DEFAULT_DIV = 2,
   localparam int unsigned CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [NUM_CH-1:0]       ch_en,
   input  logic                    sync_restart,
   input  logic                    cfg_valid,
   output logic                    cfg_ready,
   input  logic [CH_W-1:0]         cfg_ch,
   input  logic [CNT_W-1:0]        cfg_div,
`ifdef CLK_DIVIDER_MULTI_PHASE_EN
   input  logic [CNT_W-1:0]        cfg_phase,
`endif
   output logic [NUM_CH-1:0]       tick,
   output logic [NUM_CH-1:0]       clk_out,
   output logic [NUM_CH*CNT_W-1:0] div_cur
);

   logic [NUM_CH-1:0] pending_w;
   logic [NUM_CH-1:0] wr_w;
   logic              accept;

   // Out-of-range channel numbers are accepted and dropped so a bad
   // address can never stall the config port.
   always_comb begin
      cfg_ready = 1'b1;
      wr_w      = '0;
      for (int unsigned i = 0; i < NUM_CH; i++) begin
         if (32'(cfg_ch) == i)
            cfg_ready = !pending_w[i];
      end
      accept = cfg_valid && cfg_ready;
      for (int unsigned i = 0; i < NUM_CH; i++) begin
         wr_w[i] = accept && (32'(cfg_ch) == i);
      end
   end

   for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
      clk_div_channel #(
         .CNT_W       (CNT_W),
         .DEFAULT_DIV (DEFAULT_DIV)
      ) u_ch (
         .clk          (clk),
         .rst          (rst),
         .en           (ch_en[g]),
         .sync_restart (sync_restart),
         .wr           (wr_w[g]),
         .wr_div       (cfg_div),
`ifdef CLK_DIVIDER_MULTI_PHASE_EN
         .wr_phase     (cfg_phase),
`endif
         .pending      (pending_w[g]),
         .tick         (tick[g]),
         .clk_out      (clk_out[g]),
         .div          (div_cur[g*CNT_W +: CNT_W])
      );
   end

endmodule

// File: tb/tb_clk_divider_multi.sv
// Self-checking bench for clk_divider_multi (4 channels, 16-bit, default div 2).
// Table rows hold per-cycle inputs and hand-derived expected outputs; the
// expected outputs go through a scoreboard queue and are compared after the
// clock edge. Hand sequences cover async reset with a pending write and,
// with CLK_DIVIDER_MULTI_PHASE_EN defined, phase skew and clamping.
module tb_clk_divider_multi;

   localparam int unsigned NUM_CH = 4;
   localparam int unsigned CNT_W  = 16;

   logic        clk = 1'b0;
   logic        rst;
   logic [3:0]  ch_en;
   logic        sync_restart;
   logic        cfg_valid;
   logic        cfg_ready;
   logic [1:0]  cfg_ch;
   logic [15:0] cfg_div;
`ifdef CLK_DIVIDER_MULTI_PHASE_EN
   logic [15:0] cfg_phase;
`endif
   logic [3:0]  tick;
   logic [3:0]  clk_out;
   logic [63:0] div_cur;

   always #5 clk = ~clk;

   clk_divider_multi #(
      .NUM_CH      (NUM_CH),
      .CNT_W       (CNT_W),
      .DEFAULT_DIV (2)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .ch_en        (ch_en),
      .sync_restart (sync_restart),
      .cfg_valid    (cfg_valid),
      .cfg_ready    (cfg_ready),
      .cfg_ch       (cfg_ch),
      .cfg_div      (cfg_div),
`ifdef CLK_DIVIDER_MULTI_PHASE_EN
      .cfg_phase    (cfg_phase),
`endif
      .tick         (tick),
      .clk_out      (clk_out),
      .div_cur      (div_cur)
   );

   typedef struct {
      logic [3:0]  en;
      logic        sync;
      logic        vld;
      logic [1:0]  ch;
      logic [15:0] div;
      logic        rdy;
      logic [3:0]  tick;
      logic [3:0]  clko;
      logic [15:0] dsel;
   } vec_t;

   typedef struct {
      int          idx;
      logic [1:0]  ch;
      logic [3:0]  tick;
      logic [3:0]  clko;
      logic [15:0] dsel;
   } exp_t;

   vec_t tbl[$];
   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [15:0] div_of(input logic [1:0] ch);
      return div_cur[32'(ch)*16 +: 16];
   endfunction

   task automatic drive(input logic [3:0] en, input logic sync, input logic vld,
                        input logic [1:0] ch, input logic [15:0] div);
      ch_en        = en;
      sync_restart = sync;
      cfg_valid    = vld;
      cfg_ch       = ch;
      cfg_div      = div;
   endtask

   // Drive at the falling edge, then sample 1 time unit after the rising edge.
   task automatic step(input logic [3:0] en, input logic sync, input logic vld,
                       input logic [1:0] ch, input logic [15:0] div);
      @(negedge clk);
      drive(en, sync, vld, ch, div);
      @(posedge clk);
      #1;
   endtask

   task automatic add(input logic [3:0] en, input logic sync, input logic vld,
                      input logic [1:0] ch, input logic [15:0] div, input logic rdy,
                      input logic [3:0] tk, input logic [3:0] co, input logic [15:0] ds);
      vec_t v;
      v.en = en; v.sync = sync; v.vld = vld; v.ch = ch; v.div = div;
      v.rdy = rdy; v.tick = tk; v.clko = co; v.dsel = ds;
      tbl.push_back(v);
   endtask

   initial begin
      exp_t e;
      rst = 1'b1;
      drive(4'b0000, 1'b0, 1'b0, 2'd0, 16'd0);
`ifdef CLK_DIVIDER_MULTI_PHASE_EN
      cfg_phase = 16'd0;
`endif
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("reset_tick", 64'(tick), 64'd0);
      chk("reset_clk_out", 64'(clk_out), 64'd0);
      chk("reset_div_cur", div_cur, {4{16'd2}});
      chk("reset_ready", 64'(cfg_ready), 64'd1);

      //   en      sy  vl  ch  div    rdy  tick     clk_out  div[ch]
      // ch0+ch1 at default div 2
      add(4'b0011, 0, 0, 0, 16'd0, 1, 4'b0000, 4'b0000, 16'd2);
      add(4'b0011, 0, 0, 0, 16'd0, 1, 4'b0011, 4'b0011, 16'd2);
      add(4'b0011, 0, 0, 0, 16'd0, 1, 4'b0000, 4'b0000, 16'd2);
      add(4'b0011, 0, 0, 0, 16'd0, 1, 4'b0011, 4'b0011, 16'd2);
      // ch1 <= 5 while running: old period finishes, then 2 low / 3 high
      add(4'b0011, 0, 1, 1, 16'd5, 1, 4'b0000, 4'b0000, 16'd2);
      add(4'b0011, 0, 0, 1, 16'd0, 0, 4'b0011, 4'b0011, 16'd2);
      add(4'b0011, 0, 0, 1, 16'd0, 0, 4'b0000, 4'b0000, 16'd5);
      add(4'b0011, 0, 0, 1, 16'd0, 1, 4'b0001, 4'b0001, 16'd5);
      add(4'b0011, 0, 0, 1, 16'd0, 1, 4'b0000, 4'b0010, 16'd5);
      add(4'b0011, 0, 0, 1, 16'd0, 1, 4'b0001, 4'b0011, 16'd5);
      add(4'b0011, 0, 0, 1, 16'd0, 1, 4'b0010, 4'b0010, 16'd5);
      add(4'b0011, 0, 0, 1, 16'd0, 1, 4'b0001, 4'b0001, 16'd5);
      add(4'b0011, 0, 0, 1, 16'd0, 1, 4'b0000, 4'b0000, 16'd5);
      // bypass divisors 0 (ch2) and 1 (ch3) written while disabled
      add(4'b0000, 0, 1, 2, 16'd0, 1, 4'b0000, 4'b0000, 16'd2);
      add(4'b0000, 0, 1, 3, 16'd1, 1, 4'b0000, 4'b0000, 16'd2);
      add(4'b1100, 0, 0, 2, 16'd0, 1, 4'b1100, 4'b0000, 16'd0);
      add(4'b1100, 0, 0, 3, 16'd0, 1, 4'b1100, 4'b0000, 16'd1);
      add(4'b1100, 0, 0, 3, 16'd0, 1, 4'b1100, 4'b0000, 16'd1);
      // ch0=3, ch1=6 then sync_restart; ticks coincide every 6 cycles
      add(4'b0000, 0, 1, 0, 16'd3, 1, 4'b0000, 4'b0000, 16'd2);
      add(4'b0000, 0, 1, 1, 16'd6, 1, 4'b0000, 4'b0000, 16'd5);
      add(4'b0011, 1, 0, 1, 16'd0, 0, 4'b0000, 4'b0000, 16'd6);
      add(4'b0011, 0, 0, 0, 16'd0, 1, 4'b0000, 4'b0001, 16'd3);
      add(4'b0011, 0, 0, 0, 16'd0, 1, 4'b0001, 4'b0001, 16'd3);
      add(4'b0011, 0, 0, 0, 16'd0, 1, 4'b0000, 4'b0010, 16'd3);
      add(4'b0011, 0, 0, 0, 16'd0, 1, 4'b0000, 4'b0011, 16'd3);
      add(4'b0011, 0, 0, 0, 16'd0, 1, 4'b0011, 4'b0011, 16'd3);
      add(4'b0011, 0, 0, 0, 16'd0, 1, 4'b0000, 4'b0000, 16'd3);
      // sync_restart mid-count
      add(4'b0011, 0, 0, 0, 16'd0, 1, 4'b0000, 4'b0001, 16'd3);
      add(4'b0011, 1, 0, 0, 16'd0, 1, 4'b0000, 4'b0000, 16'd3);
      add(4'b0011, 0, 0, 0, 16'd0, 1, 4'b0000, 4'b0001, 16'd3);
      // sync_restart with a same-cycle write: applied at once, nothing pending
      add(4'b0011, 1, 1, 0, 16'd4, 1, 4'b0000, 4'b0000, 16'd4);
      add(4'b0011, 0, 0, 0, 16'd0, 1, 4'b0000, 4'b0000, 16'd4);

      for (int i = 0; i < tbl.size(); i++) begin
         @(negedge clk);
         drive(tbl[i].en, tbl[i].sync, tbl[i].vld, tbl[i].ch, tbl[i].div);
         #1;
         chk($sformatf("row%0d_ready", i), 64'(cfg_ready), 64'(tbl[i].rdy));
         e.idx = i; e.ch = tbl[i].ch; e.tick = tbl[i].tick;
         e.clko = tbl[i].clko; e.dsel = tbl[i].dsel;
         sb.push_back(e);
         @(posedge clk);
         #1;
         e = sb.pop_front();
         chk($sformatf("row%0d_tick", e.idx), 64'(tick), 64'(e.tick));
         chk($sformatf("row%0d_clk_out", e.idx), 64'(clk_out), 64'(e.clko));
         chk($sformatf("row%0d_div_cur", e.idx), 64'(div_of(e.ch)), 64'(e.dsel));
      end

      // ch2: div 6, then a pending write of 9 at cnt=1, async reset at cnt=3
      @(negedge clk);
      drive(4'b0111, 1'b0, 1'b1, 2'd2, 16'd6);
      #1 chk("h1_ready", 64'(cfg_ready), 64'd1);
      @(posedge clk); #1;
      chk("h1_tick2", 64'(tick[2]), 64'd1);
      @(negedge clk);
      drive(4'b0111, 1'b0, 1'b0, 2'd2, 16'd0);
      #1 chk("h2_ready", 64'(cfg_ready), 64'd0);
      @(posedge clk); #1;
      chk("h2_div2", 64'(div_of(2'd2)), 64'd6);
      chk("h2_tick2", 64'(tick[2]), 64'd0);
      step(4'b0111, 1'b0, 1'b0, 2'd2, 16'd0);
      step(4'b0111, 1'b0, 1'b1, 2'd2, 16'd9);
      step(4'b0111, 1'b0, 1'b0, 2'd2, 16'd0);
      chk("h5_ready", 64'(cfg_ready), 64'd0);
      chk("h5_clk2", 64'(clk_out[2]), 64'd1);
      #2 rst = 1'b1;
      #1;
      chk("arst_tick", 64'(tick), 64'd0);
      chk("arst_clk_out", 64'(clk_out), 64'd0);
      chk("arst_div_cur", div_cur, {4{16'd2}});
      chk("arst_ready", 64'(cfg_ready), 64'd1);
      @(negedge clk);
      rst = 1'b0;
      drive(4'b0100, 1'b0, 1'b0, 2'd2, 16'd0);
      for (int k = 0; k < 4; k++) begin
         @(posedge clk); #1;
         chk($sformatf("post_rst_tick2_%0d", k), 64'(tick[2]), 64'(k % 2));
      end
      chk("post_rst_div2", 64'(div_of(2'd2)), 64'd2);

`ifdef CLK_DIVIDER_MULTI_PHASE_EN
      // ch0 div4 ph0, ch1 div4 ph2, ch2 div4 ph9 (clamped to 3), then restart
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      cfg_phase = 16'd0;
      step(4'b0000, 1'b0, 1'b1, 2'd0, 16'd4);
      @(negedge clk) cfg_phase = 16'd2;
      step(4'b0000, 1'b0, 1'b1, 2'd1, 16'd4);
      @(negedge clk) cfg_phase = 16'd9;
      step(4'b0000, 1'b0, 1'b1, 2'd2, 16'd4);
      step(4'b0111, 1'b1, 1'b0, 2'd0, 16'd0);
      chk("ph0_tick", 64'(tick[2:0]), 64'(3'b100));
      chk("ph0_clk", 64'(clk_out[2:0]), 64'(3'b110));
      step(4'b0111, 1'b0, 1'b0, 2'd0, 16'd0);
      chk("ph1_tick", 64'(tick[2:0]), 64'(3'b010));
      chk("ph1_clk", 64'(clk_out[2:0]), 64'(3'b010));
      step(4'b0111, 1'b0, 1'b0, 2'd0, 16'd0);
      chk("ph2_tick", 64'(tick[2:0]), 64'(3'b000));
      chk("ph2_clk", 64'(clk_out[2:0]), 64'(3'b001));
      step(4'b0111, 1'b0, 1'b0, 2'd0, 16'd0);
      chk("ph3_tick", 64'(tick[2:0]), 64'(3'b001));
      chk("ph3_clk", 64'(clk_out[2:0]), 64'(3'b101));
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
